// File: rtl/qbert_cube_tracker_if.sv
// qbert_cube_tracker_if: NIOS/renderer-facing signal bundle of the cube tracker
interface qbert_cube_tracker_if #(parameter int N_cube = 3);
  localparam int NC_W = $clog2(N_cube + 1);
  logic              start;
  logic              done_move;
  logic [N_cube-1:0] position_qb;
  logic              bad_jump;
  logic [N_cube-1:0] color_state;
  logic [NC_W-1:0]   n_colored;
  logic [2:0]        lives;
  logic              KO_qb;
  logic              level_done;
  logic              game_over;
  logic [2:0]        fsm_state;
  modport master (
    output start, done_move, position_qb, bad_jump,
    input  color_state, n_colored, lives, KO_qb, level_done, game_over, fsm_state
  );
  modport slave (
    input  start, done_move, position_qb, bad_jump,
    output color_state, n_colored, lives, KO_qb, level_done, game_over, fsm_state
  );
endinterface

// File: rtl/qbert_cube_tracker.sv
// qbert_cube_tracker: tracks coloured cubes, lives and fall penalty for one Qbert level
module qbert_cube_tracker #(
  parameter int N_cube  = 3,
  parameter int N_LIVES = 3,
  parameter int KO_HOLD = 16
) (
  input logic                 CLK_33,
  input logic                 reset,
  qbert_cube_tracker_if.slave bus
);
  localparam int NC_W = $clog2(N_cube + 1);
  typedef enum logic [2:0] {
    IDLE = 3'd0, PLAY = 3'd1, LAND = 3'd2, FALL = 3'd3, WIN = 3'd4, OVER = 3'd5
  } state_t;
  state_t            state;
  logic              done_move_d;
  logic [N_cube-1:0] pos_lat;
  logic [N_cube-1:0] color_q;
  logic [N_cube-1:0] color_nx;
  logic [NC_W-1:0]   n_q;
  logic [NC_W-1:0]   n_nx;
  logic [2:0]        lives_q;
  logic              ko_q;
  logic              win_q;
  logic              over_q;
  logic [7:0]        ko_cnt;
  logic              land_evt;
  logic              one_hot;
  logic              restart;
  assign land_evt = bus.done_move && !done_move_d;
  assign one_hot  = (bus.position_qb != '0) && ((bus.position_qb & (bus.position_qb - N_cube'(1))) == '0);
  assign restart  = bus.start && state != WIN;
  // colour set and count as they would be after the LAND cycle
  always_comb begin
    color_nx = color_q | pos_lat;
    n_nx     = n_q + NC_W'(|(pos_lat & ~color_q));
  end
  // game FSM with all outputs registered alongside the state
  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done_move_d <= 1'b0;
      pos_lat     <= '0;
      color_q     <= '0;
      n_q         <= '0;
      lives_q     <= 3'd0;
      ko_q        <= 1'b0;
      win_q       <= 1'b0;
      over_q      <= 1'b0;
      ko_cnt      <= 8'd0;
    end else begin
      done_move_d <= bus.done_move;
      if (restart) begin
        state   <= PLAY;
        lives_q <= 3'(N_LIVES);
        color_q <= '0;
        n_q     <= '0;
        ko_q    <= 1'b0;
        ko_cnt  <= 8'd0;
        win_q   <= 1'b0;
        over_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          PLAY: if (land_evt) begin
            if (bus.bad_jump || !one_hot) begin
              state   <= FALL;
              lives_q <= lives_q - 3'(lives_q != 3'd0);
              ko_q    <= 1'b1;
              ko_cnt  <= 8'(KO_HOLD - 1);
            end else begin
              pos_lat <= bus.position_qb;
              state   <= LAND;
            end
          end
          LAND: begin
            color_q <= color_nx;
            n_q     <= n_nx;
            state   <= (n_nx == NC_W'(N_cube)) ? WIN : PLAY;
          end
          FALL: if (ko_cnt == 8'd0) begin
            ko_q  <= 1'b0;
            state <= (lives_q == 3'd0) ? OVER : PLAY;
          end else begin
            ko_cnt <= ko_cnt - 8'd1;
          end
          WIN: begin
            win_q <= !bus.start;
            if (bus.start) begin
              color_q <= '0;
              n_q     <= '0;
              state   <= PLAY;
            end
          end
          OVER: over_q <= 1'b1;
          default: begin
            state   <= IDLE;
            color_q <= '0;
            n_q     <= '0;
            lives_q <= 3'd0;
            ko_q    <= 1'b0;
            ko_cnt  <= 8'd0;
            win_q   <= 1'b0;
            over_q  <= 1'b0;
          end
        endcase
      end
    end
  end
  assign bus.color_state = color_q;
  assign bus.n_colored   = n_q;
  assign bus.lives       = lives_q;
  assign bus.KO_qb       = ko_q;
  assign bus.level_done  = win_q;
  assign bus.game_over   = over_q;
  assign bus.fsm_state   = state;
endmodule

// File: tb/tb_qbert_cube_tracker.sv
// tb_qbert_cube_tracker: directed game scenarios checked against a cycle model of the rules
module tb_qbert_cube_tracker;
  localparam int N_cube  = 3;
  localparam int N_LIVES = 3;
  localparam int KO_HOLD = 16;
  logic CLK_33 = 1'b0;
  logic reset  = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;
  bit   chk_en = 1'b0;
  qbert_cube_tracker_if #(.N_cube(N_cube)) bus();
  qbert_cube_tracker #(.N_cube(N_cube), .N_LIVES(N_LIVES), .KO_HOLD(KO_HOLD)) dut (
    .CLK_33(CLK_33),
    .reset (reset),
    .bus   (bus)
  );
  always #5 CLK_33 = ~CLK_33;
  int       m_st;
  bit [2:0] m_col;
  bit [2:0] m_pend;
  int       m_lives;
  int       m_ko;
  int       m_age;
  bit       m_prev;
  bit       m_land;
  // game rules: m_ko counts remaining penalty cycles, m_age counts cycles since entering m_st
  always @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      m_st = 0; m_col = 0; m_pend = 0; m_lives = 0; m_ko = 0; m_age = 0; m_prev = 0;
    end else begin
      m_land = bus.done_move && !m_prev;
      m_prev = bus.done_move;
      m_age++;
      if (bus.start && m_st == 4) begin
        m_st = 1; m_col = 0; m_age = 0;
      end else if (bus.start) begin
        m_st = 1; m_col = 0; m_lives = N_LIVES; m_ko = 0; m_age = 0;
      end else if (m_st == 1 && m_land) begin
        m_age = 0;
        if (bus.bad_jump || $countones(bus.position_qb) != 1) begin
          m_st = 3; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_ko = KO_HOLD;
        end else begin
          m_st = 2; m_pend = bus.position_qb;
        end
      end else if (m_st == 2) begin
        m_col |= m_pend;
        m_st = ($countones(m_col) == N_cube) ? 4 : 1;
        m_age = 0;
      end else if (m_st == 3) begin
        m_ko--;
        if (m_ko == 0) begin
          m_st = (m_lives == 0) ? 5 : 1;
          m_age = 0;
        end
      end
    end
  end
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  // every-cycle comparison of all outputs against the model
  always @(negedge CLK_33) begin
    if (chk_en) begin
      check("color_state", int'(bus.color_state), int'(m_col));
      check("n_colored", int'(bus.n_colored), $countones(m_col));
      check("lives", int'(bus.lives), m_lives);
      check("KO_qb", int'(bus.KO_qb), int'(m_ko > 0));
      check("level_done", int'(bus.level_done), int'(m_st == 4 && m_age >= 1));
      check("game_over", int'(bus.game_over), int'(m_st == 5 && m_age >= 1));
      check("fsm_state", int'(bus.fsm_state), m_st);
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK_33);
      #2;
    end
  endtask
  task automatic land(input logic [2:0] pos, input logic bad);
    bus.position_qb = pos;
    bus.bad_jump    = bad;
    bus.done_move   = 1'b1;
    tick(3);
    bus.done_move   = 1'b0;
    tick(2);
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic fall_count(output int cnt);
    cnt = 0;
    bus.position_qb = 3'b010;
    bus.bad_jump    = 1'b1;
    bus.done_move   = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (i == 2) bus.done_move = 1'b0;
      if (bus.KO_qb) cnt++;
    end
    bus.bad_jump = 1'b0;
  endtask
  initial begin
    int ko_len;
    bus.start = 1'b0; bus.done_move = 1'b0; bus.position_qb = 3'b000; bus.bad_jump = 1'b0;
    chk_en = 1'b1;
    tick(3);
    check("reset color_state", int'(bus.color_state), 0);
    check("reset lives", int'(bus.lives), 0);
    check("reset fsm_state", int'(bus.fsm_state), 0);
    reset = 1'b1;
    tick(3);
    check("idle hold fsm_state", int'(bus.fsm_state), 0);
    pulse_start();
    check("start lives", int'(bus.lives), 3);
    check("start fsm_state", int'(bus.fsm_state), 1);
    bus.position_qb = 3'b010;
    bus.done_move   = 1'b1;
    tick();
    check("edge+1 color_state", int'(bus.color_state), 0);
    check("edge+1 fsm_state", int'(bus.fsm_state), 2);
    tick();
    check("edge+2 color_state", int'(bus.color_state), 3'b010);
    check("edge+2 n_colored", int'(bus.n_colored), 1);
    tick(3);
    bus.done_move = 1'b0;
    tick(2);
    check("single update n_colored", int'(bus.n_colored), 1);
    pulse_start();
    land(3'b001, 1'b0);
    land(3'b001, 1'b0);
    check("revisit n_colored", int'(bus.n_colored), 1);
    check("revisit color_state", int'(bus.color_state), 3'b001);
    land(3'b100, 1'b0);
    land(3'b010, 1'b0);
    check("win color_state", int'(bus.color_state), 3'b111);
    check("win n_colored", int'(bus.n_colored), 3);
    check("win fsm_state", int'(bus.fsm_state), 4);
    check("win level_done", int'(bus.level_done), 1);
    land(3'b001, 1'b0);
    check("win ignores land fsm", int'(bus.fsm_state), 4);
    check("win ignores land n", int'(bus.n_colored), 3);
    pulse_start();
    check("win restart fsm", int'(bus.fsm_state), 1);
    check("win restart color", int'(bus.color_state), 0);
    check("win restart lives", int'(bus.lives), 3);
    land(3'b100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      fall_count(ko_len);
      check("fall KO cycles", ko_len, KO_HOLD);
      check("fall lives", int'(bus.lives), 2 - k);
    end
    check("fall keeps color", int'(bus.color_state), 3'b100);
    check("over fsm_state", int'(bus.fsm_state), 5);
    check("over game_over", int'(bus.game_over), 1);
    pulse_start();
    check("over restart lives", int'(bus.lives), 3);
    check("over restart fsm", int'(bus.fsm_state), 1);
    land(3'b011, 1'b0);
    check("illegal pos fsm", int'(bus.fsm_state), 3);
    check("illegal pos lives", int'(bus.lives), 2);
    tick(20);
    bus.position_qb = 3'b010; bus.bad_jump = 1'b1; bus.done_move = 1'b1;
    tick();
    bus.done_move = 1'b0;
    tick(3);
    reset = 1'b0;
    #1;
    check("async reset fsm", int'(bus.fsm_state), 0);
    check("async reset KO", int'(bus.KO_qb), 0);
    check("async reset lives", int'(bus.lives), 0);
    tick();
    reset = 1'b1;
    bus.bad_jump = 1'b0;
    tick();
    pulse_start();
    bus.position_qb = 3'b001; bus.bad_jump = 1'b1; bus.done_move = 1'b1;
    tick(2);
    check("fall KO high", int'(bus.KO_qb), 1);
    bus.done_move = 1'b0; bus.bad_jump = 1'b0;
    pulse_start();
    check("start drops KO", int'(bus.KO_qb), 0);
    check("start in fall fsm", int'(bus.fsm_state), 1);
    land(3'b001, 1'b0);
    check("pre-restart color", int'(bus.color_state), 3'b001);
    bus.position_qb = 3'b100; bus.done_move = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(2);
    bus.done_move = 1'b0;
    tick(2);
    check("start beats land color", int'(bus.color_state), 0);
    check("start beats land fsm", int'(bus.fsm_state), 1);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
